pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central control unit for the 3-stage processor pipeline: fetch, r1 (decode/operand read), r2 (execute/memory).
- Observes the r1 and r2 stage registers and the data-memory read handshake.
- Generates the stall, hold and flush controls for fetch, r1 and r2.
- Sequences load wait, load-use bubbles, taken-branch squashes and processor halt, and keeps saturating stall and flush statistics.

Parameters:
- FLUSH_LEN, 1, number of cycles r1_flush stays asserted per taken branch (1..7).
- MEM_TIMEOUT, 16, maximum cycles spent in LOAD_WAIT before aborting with mem_err (2..255).
- CNT_W, 16, width of the stall and flush statistic counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- r1_src1  in  3  r1 operand-1 register index
- r1_src2  in  3  r1 operand-2 register index
- r1_src1_used  in  1  r1 instruction reads src1
- r1_src2_used  in  1  r1 instruction reads src2
- r2_destination  in  3  r2 destination register index
- r2_read  in  1  r2 holds a load
- r2_pc_load  in  1  r2 absolute branch taken
- r2_pc_loadr  in  1  r2 relative branch taken
- r2_pc_halt  in  1  r2 holds a halt
- mem_rd_valid  in  1  data memory returns load data this cycle
- resume  in  1  single-cycle pulse that leaves HALTED
- cnt_clr  in  1  synchronous clear of the statistic counters
- fetch_stall  out  1  hold PC and fetch
- r1_stall  out  1  hold the r1 register
- r1_flush  out  1  zero the r1 register
- r2_hold  out  1  hold the r2 register
- r2_pc_flush  out  1  load a bubble into r2
- halted  out  1  processor halted
- mem_err  out  1  sticky load-timeout flag
- stall_cnt  out  CNT_W  cycles with fetch_stall=1, saturating
- flush_cnt  out  CNT_W  taken branches, saturating

Behaviour:
- Timing model:
  - State, wait counter, flush counter, mem_err and the statistics are registered.
  - All control outputs are combinational from the current state and inputs (same-cycle response).
- Reset (rst_n=0, any time, including mid-LOAD_WAIT, mid-FLUSH or while HALTED):
  - State=RUN; all counters=0; mem_err=0.
  - Outputs then read 0 because RUN with quiet inputs decodes to 0.
- FSM states: RUN, LOAD_WAIT, FLUSH, HALTED.
- RUN: the conditions below are evaluated in priority order; the first match wins.
  - 1 Halt. r2_pc_halt=1: assert fetch_stall, r1_stall, r2_hold. Go to HALTED.
  - 2 Load wait. r2_read=1 and mem_rd_valid=0: assert fetch_stall, r1_stall, r2_hold. Clear the wait counter to 1. Go to LOAD_WAIT.
  - 3 Taken branch. r2_pc_load or r2_pc_loadr: assert r1_flush and r2_pc_flush; flush_cnt+1.
    - If FLUSH_LEN>1, load the flush counter with FLUSH_LEN-1 and go to FLUSH.
  - 4 Load-use hazard. r2_read=1 (data valid) and r2_destination equals an r1 source whose *_used bit is 1: one bubble. Assert fetch_stall, r1_stall, r2_pc_flush. Stay in RUN.
  - Otherwise all controls are 0.
- LOAD_WAIT:
  - fetch_stall, r1_stall, r2_hold stay 1 while mem_rd_valid=0; wait counter +1 per cycle.
  - mem_rd_valid=1: r2_hold=0 that cycle; the r1/r2 dependency check of rule 4 applies and can add its bubble. Go to RUN.
  - Branch or halt bits held in r2 are acted on once the state is back in RUN (r2 did not advance).
  - Wait counter reaches MEM_TIMEOUT without valid: set mem_err (sticky until reset), release the holds that cycle, go to RUN.
- FLUSH:
  - r1_flush=1 every cycle; flush counter -1; go to RUN when it reaches 0.
  - A new taken branch in r2 during FLUSH reloads the counter and increments flush_cnt.
  - An r2_pc_halt seen during FLUSH is deferred to RUN.
- HALTED:
  - halted=1; fetch_stall, r1_stall, r2_hold=1 every cycle. mem_rd_valid is ignored.
  - resume=1: in that cycle assert r1_flush and r2_pc_flush with r2_hold=0, then go to RUN.
  - resume outside HALTED is ignored.
- Statistics:
  - Counters saturate at all-ones.
  - cnt_clr has priority over an increment in the same cycle.
- Matching on r1 sources uses the 3-bit index only; register 0 is not special.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state typedef (RUN=0, LOAD_WAIT=1, FLUSH=2, HALTED=3);
  - the register-index width constant (3);
  - the default FLUSH_LEN and MEM_TIMEOUT constants.
- One natural sub-module, sat_counter (CNT_W, inc, clr), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Load hit. r2_read=1, mem_rd_valid=1, r2_destination=3, r1_src1=3, r1_src1_used=1 → exactly 1 cycle of fetch_stall=r1_stall=r2_pc_flush=1, stall_cnt=1, state stays RUN.
- Load miss. r2_read=1, mem_rd_valid low for 4 cycles → fetch_stall, r1_stall, r2_hold high 4 cycles, drop in the valid cycle, stall_cnt=4. Repeat with no valid for 16 cycles → mem_err=1, holds released at cycle 16.
- Taken branch. r2_pc_loadr=1 with FLUSH_LEN=3 → r1_flush high 3 consecutive cycles, r2_pc_flush high in the first only, flush_cnt=1. A second branch in cycle 2 → r1_flush extended to cycle 4, flush_cnt=2.
- Halt then resume. r2_pc_halt=1 → halted=1 and stalls held for 10 cycles with no resume; resume pulse → r1_flush=r2_pc_flush=1 in that cycle, halted=0 next cycle.
- Priority. r2_pc_halt=1 and r2_pc_load=1 in the same RUN cycle → HALTED entered, flush_cnt unchanged. Drive rst_n=0 mid-LOAD_WAIT → all outputs 0 and state RUN asynchronously.
- Saturation. CNT_W=4, hold a load miss 20 cycles → stall_cnt=15. cnt_clr asserted together with a stall → stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the 3-stage pipeline control unit.
// Contents: control FSM state type, register-index width and the default
// flush length and load-timeout values.
package pipe_ctrl_pkg;

  localparam int unsigned RegIdxW       = 3;
  localparam int unsigned DefFlushLen   = 1;
  localparam int unsigned DefMemTimeout = 16;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLoadWait = 2'd1,
    StFlush    = 2'd2,
    StHalted   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n (async active-low), inc (count enable), clr (clear,
// wins over inc), cnt (current value, sticks at all-ones).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / stall / flush controller for the fetch -> r1 -> r2 pipeline.
// Inputs:  r1 operand indices and use bits, r2 destination and load/branch/
//          halt bits, data-memory read-valid, resume pulse, stats clear.
// Outputs: fetch_stall, r1_stall, r1_flush, r2_hold, r2_pc_flush (all
//          combinational from state + inputs), halted, sticky mem_err and
//          saturating stall/flush statistics.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_LEN   = DefFlushLen,
  parameter int unsigned MEM_TIMEOUT = DefMemTimeout,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RegIdxW-1:0] r1_src1,
  input  logic [RegIdxW-1:0] r1_src2,
  input  logic               r1_src1_used,
  input  logic               r1_src2_used,
  input  logic [RegIdxW-1:0] r2_destination,
  input  logic               r2_read,
  input  logic               r2_pc_load,
  input  logic               r2_pc_loadr,
  input  logic               r2_pc_halt,
  input  logic               mem_rd_valid,
  input  logic               resume,
  input  logic               cnt_clr,
  output logic               fetch_stall,
  output logic               r1_stall,
  output logic               r1_flush,
  output logic               r2_hold,
  output logic               r2_pc_flush,
  output logic               halted,
  output logic               mem_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // The wait counter enters LOAD_WAIT at 1; the cycle in which it would
  // step from MEM_TIMEOUT-1 to MEM_TIMEOUT is the abort cycle.
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);
  localparam logic [2:0] FlushReload = 3'(FLUSH_LEN - 1);

  ctrl_state_e state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [2:0]  fl_q, fl_d;
  logic        mem_err_q, mem_err_d;
  logic        branch, hazard, flush_inc;

  assign branch = r2_pc_load | r2_pc_loadr;
  // Load in r2 whose destination feeds an operand r1 actually reads.
  assign hazard = r2_read &&
                  ((r1_src1_used && (r1_src1 == r2_destination)) ||
                   (r1_src2_used && (r1_src2 == r2_destination)));

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    fl_d        = fl_q;
    mem_err_d   = mem_err_q;
    flush_inc   = 1'b0;
    fetch_stall = 1'b0;
    r1_stall    = 1'b0;
    r1_flush    = 1'b0;
    r2_hold     = 1'b0;
    r2_pc_flush = 1'b0;
    halted      = 1'b0;

    unique case (state_q)
      StRun: begin
        if (r2_pc_halt) begin
          fetch_stall = 1'b1;
          r1_stall    = 1'b1;
          r2_hold     = 1'b1;
          state_d     = StHalted;
        end else if (r2_read && !mem_rd_valid) begin
          fetch_stall = 1'b1;
          r1_stall    = 1'b1;
          r2_hold     = 1'b1;
          wait_d      = 8'd1;
          state_d     = StLoadWait;
        end else if (branch) begin
          r1_flush    = 1'b1;
          r2_pc_flush = 1'b1;
          flush_inc   = 1'b1;
          if (FLUSH_LEN > 1) begin
            fl_d    = FlushReload;
            state_d = StFlush;
          end
        end else if (hazard) begin
          fetch_stall = 1'b1;
          r1_stall    = 1'b1;
          r2_pc_flush = 1'b1;
        end
      end

      StLoadWait: begin
        // Branch/halt bits still sitting in r2 are left for RUN to act on.
        if (mem_rd_valid) begin
          state_d = StRun;
          if (hazard) begin
            fetch_stall = 1'b1;
            r1_stall    = 1'b1;
            r2_pc_flush = 1'b1;
          end
        end else if (wait_q >= TimeoutLast) begin
          mem_err_d = 1'b1;
          state_d   = StRun;
        end else begin
          fetch_stall = 1'b1;
          r1_stall    = 1'b1;
          r2_hold     = 1'b1;
          wait_d      = wait_q + 8'd1;
        end
      end

      StFlush: begin
        // Halt is deferred to RUN; a fresh branch restarts the flush window.
        r1_flush = 1'b1;
        if (branch) begin
          r2_pc_flush = 1'b1;
          flush_inc   = 1'b1;
          fl_d        = FlushReload;
        end else begin
          fl_d = fl_q - 3'd1;
          if (fl_q <= 3'd1) begin
            state_d = StRun;
          end
        end
      end

      StHalted: begin
        halted      = 1'b1;
        fetch_stall = 1'b1;
        r1_stall    = 1'b1;
        if (resume) begin
          r1_flush    = 1'b1;
          r2_pc_flush = 1'b1;
          state_d     = StRun;
        end else begin
          r2_hold = 1'b1;
        end
      end

      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      wait_q    <= '0;
      fl_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      fl_q      <= fl_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fetch_stall),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .clr   (cnt_clr),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_LEN=3, MEM_TIMEOUT=16,
// CNT_W=4). Per-cycle expected control vectors go into a scoreboard queue
// as stimulus is applied; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CW = 4;

  // Vector order: {fetch_stall, r1_stall, r1_flush, r2_hold, r2_pc_flush, halted}
  localparam logic [5:0] CQ     = 6'b000000;
  localparam logic [5:0] CSTALL = 6'b110100;
  localparam logic [5:0] CBUB   = 6'b110010;
  localparam logic [5:0] CBR    = 6'b001010;
  localparam logic [5:0] CFL    = 6'b001000;
  localparam logic [5:0] CHLT   = 6'b110101;
  localparam logic [5:0] CRES   = 6'b111011;
  localparam logic [5:0] ALL    = 6'b111111;

  typedef struct {
    logic [5:0] ctl;
    logic [5:0] mask;
    int         tag;
  } exp_t;

  logic          clk, rst_n;
  logic [2:0]    r1_src1, r1_src2, r2_destination;
  logic          r1_src1_used, r1_src2_used;
  logic          r2_read, r2_pc_load, r2_pc_loadr, r2_pc_halt;
  logic          mem_rd_valid, resume, cnt_clr;
  logic          fetch_stall, r1_stall, r1_flush, r2_hold, r2_pc_flush;
  logic          halted, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [5:0]    obs;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pipe_hazard_ctrl #(
    .FLUSH_LEN   (3),
    .MEM_TIMEOUT (16),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r1_src1        (r1_src1),
    .r1_src2        (r1_src2),
    .r1_src1_used   (r1_src1_used),
    .r1_src2_used   (r1_src2_used),
    .r2_destination (r2_destination),
    .r2_read        (r2_read),
    .r2_pc_load     (r2_pc_load),
    .r2_pc_loadr    (r2_pc_loadr),
    .r2_pc_halt     (r2_pc_halt),
    .mem_rd_valid   (mem_rd_valid),
    .resume         (resume),
    .cnt_clr        (cnt_clr),
    .fetch_stall    (fetch_stall),
    .r1_stall       (r1_stall),
    .r1_flush       (r1_flush),
    .r2_hold        (r2_hold),
    .r2_pc_flush    (r2_pc_flush),
    .halted         (halted),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  assign obs = {fetch_stall, r1_stall, r1_flush, r2_hold, r2_pc_flush, halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: inputs change just after posedge, outputs are
  // sampled at the following negedge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (((obs ^ e.ctl) & e.mask) !== 6'd0) begin
        errors++;
        $display("FAIL ctl tag=%0d got=%b want=%b mask=%b", e.tag, obs, e.ctl, e.mask);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic clear_inputs();
    r1_src1 = 3'd0; r1_src2 = 3'd0; r2_destination = 3'd0;
    r1_src1_used = 1'b0; r1_src2_used = 1'b0;
    r2_read = 1'b0; r2_pc_load = 1'b0; r2_pc_loadr = 1'b0; r2_pc_halt = 1'b0;
    mem_rd_valid = 1'b0; resume = 1'b0; cnt_clr = 1'b0;
  endtask

  // Queue the expected controls for the cycle just driven, then advance.
  task automatic cyc(input logic [5:0] ctl, input logic [5:0] mask, input int tag);
    exp_t e;
    e.ctl = ctl; e.mask = mask; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats(input int tag);
    cnt_clr = 1'b1;
    cyc(CQ, ALL, tag);
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, mem_err, stall_cnt, flush_cnt} !== '0) begin
      errors++;
      $display("FAIL reset got=%b/%b/%0d/%0d want=0", obs, mem_err, stall_cnt, flush_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(CQ, ALL, 1);
  endtask

  task automatic test_load_hit();
    clear_stats(9);
    r2_read = 1'b1; mem_rd_valid = 1'b1; r2_destination = 3'd3;
    r1_src1 = 3'd3; r1_src1_used = 1'b1; r1_src2 = 3'd6;
    cyc(CBUB, ALL, 10);
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++; $display("FAIL load_hit stall_cnt got=%0d want=1", stall_cnt);
    end
    r1_src1_used = 1'b0; r1_src2 = 3'd3;
    cyc(CQ, ALL, 11);
    r1_src2_used = 1'b1;
    cyc(CBUB, ALL, 12);
    r2_destination = 3'd0; r1_src1 = 3'd0; r1_src1_used = 1'b1; r1_src2 = 3'd7;
    cyc(CBUB, ALL, 13);
    r2_read = 1'b0;
    cyc(CQ, ALL, 14);
    clear_inputs();
    cyc(CQ, ALL, 15);
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++; $display("FAIL load_hit_total stall_cnt got=%0d want=3", stall_cnt);
    end
  endtask

  task automatic test_load_miss();
    clear_stats(100);
    r2_read = 1'b1; r2_destination = 3'd5;
    repeat (4) cyc(CSTALL, ALL, 101);
    mem_rd_valid = 1'b1;
    cyc(CQ, ALL, 102);
    clear_inputs();
    cyc(CQ, ALL, 103);
    checks++;
    if (stall_cnt !== 4'd4) begin
      errors++; $display("FAIL load_miss stall_cnt got=%0d want=4", stall_cnt);
    end
    // Dependent load: wait first, bubble in the data-valid cycle.
    r2_read = 1'b1; r2_destination = 3'd5; r1_src1 = 3'd5; r1_src1_used = 1'b1;
    cyc(CSTALL, ALL, 104);
    mem_rd_valid = 1'b1;
    cyc(CBUB, ALL, 105);
    clear_inputs();
    cyc(CQ, ALL, 106);
    checks++;
    if (stall_cnt !== 4'd6) begin
      errors++; $display("FAIL load_dep stall_cnt got=%0d want=6", stall_cnt);
    end
    // Timeout.
    clear_stats(109);
    r2_read = 1'b1; r2_destination = 3'd2;
    repeat (15) cyc(CSTALL, ALL, 110);
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_early mem_err got=%b want=0", mem_err);
    end
    cyc(CQ, ALL, 111);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout mem_err got=%b want=1", mem_err);
    end
    r2_read = 1'b0;
    cyc(CQ, ALL, 112);
    checks++;
    if (mem_err !== 1'b1 || stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL timeout_sticky mem_err=%b stall_cnt=%0d want 1/15", mem_err, stall_cnt);
    end
  endtask

  task automatic test_branch();
    clear_stats(200);
    r2_pc_loadr = 1'b1;
    cyc(CBR, ALL, 201);
    r2_pc_loadr = 1'b0;
    cyc(CFL, ALL, 202);
    cyc(CFL, ALL, 203);
    cyc(CQ, ALL, 204);
    checks++;
    if (flush_cnt !== 4'd1) begin
      errors++; $display("FAIL branch flush_cnt got=%0d want=1", flush_cnt);
    end
    clear_stats(210);
    r2_pc_load = 1'b1;
    cyc(CBR, ALL, 211);
    r2_pc_load = 1'b0; r2_pc_loadr = 1'b1;
    cyc(CFL, 6'b111101, 212);
    r2_pc_loadr = 1'b0;
    cyc(CFL, ALL, 213);
    cyc(CFL, ALL, 214);
    cyc(CQ, ALL, 215);
    checks++;
    if (flush_cnt !== 4'd2) begin
      errors++; $display("FAIL branch2 flush_cnt got=%0d want=2", flush_cnt);
    end
    // Halt arriving during FLUSH waits for RUN.
    clear_stats(220);
    r2_pc_load = 1'b1;
    cyc(CBR, ALL, 221);
    r2_pc_load = 1'b0; r2_pc_halt = 1'b1;
    cyc(CFL, ALL, 222);
    cyc(CFL, ALL, 223);
    cyc(CSTALL, ALL, 224);
    cyc(CHLT, ALL, 225);
    r2_pc_halt = 1'b0; resume = 1'b1;
    cyc(CRES, ALL, 226);
    resume = 1'b0;
    cyc(CQ, ALL, 227);
    checks++;
    if (flush_cnt !== 4'd1) begin
      errors++; $display("FAIL branch_halt flush_cnt got=%0d want=1", flush_cnt);
    end
  endtask

  task automatic test_halt();
    clear_stats(300);
    r2_pc_halt = 1'b1;
    cyc(CSTALL, ALL, 301);
    for (int i = 0; i < 10; i++) begin
      mem_rd_valid = i[0];
      cyc(CHLT, ALL, 302);
    end
    mem_rd_valid = 1'b0; r2_pc_halt = 1'b0; resume = 1'b1;
    cyc(CRES, ALL, 303);
    resume = 1'b0;
    cyc(CQ, ALL, 304);
    checks++;
    if (stall_cnt !== 4'd12) begin
      errors++; $display("FAIL halt stall_cnt got=%0d want=12", stall_cnt);
    end
    resume = 1'b1;
    cyc(CQ, ALL, 305);
    resume = 1'b0;
    cyc(CQ, ALL, 306);
  endtask

  task automatic test_priority();
    clear_stats(400);
    r2_pc_halt = 1'b1; r2_pc_load = 1'b1;
    cyc(CSTALL, ALL, 401);
    cyc(CHLT, ALL, 402);
    checks++;
    if (flush_cnt !== 4'd0) begin
      errors++; $display("FAIL prio_halt flush_cnt got=%0d want=0", flush_cnt);
    end
    clear_inputs(); resume = 1'b1;
    cyc(CRES, ALL, 403);
    resume = 1'b0;
    cyc(CQ, ALL, 404);
    // Load miss beats branch; branch is taken once back in RUN.
    r2_read = 1'b1; r2_pc_load = 1'b1;
    cyc(CSTALL, ALL, 411);
    mem_rd_valid = 1'b1;
    cyc(CQ, ALL, 412);
    checks++;
    if (flush_cnt !== 4'd0) begin
      errors++; $display("FAIL prio_load flush_cnt got=%0d want=0", flush_cnt);
    end
    r2_read = 1'b0; mem_rd_valid = 1'b0;
    cyc(CBR, ALL, 413);
    r2_pc_load = 1'b0;
    cyc(CFL, ALL, 414);
    cyc(CFL, ALL, 415);
    cyc(CQ, ALL, 416);
    checks++;
    if (flush_cnt !== 4'd1) begin
      errors++; $display("FAIL prio_branch flush_cnt got=%0d want=1", flush_cnt);
    end
    // Asynchronous reset in the middle of LOAD_WAIT.
    r2_read = 1'b1;
    cyc(CSTALL, ALL, 421);
    cyc(CSTALL, ALL, 422);
    clear_inputs();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, mem_err, stall_cnt, flush_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b/%b/%0d/%0d want=0", obs, mem_err, stall_cnt, flush_cnt);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(CQ, ALL, 423);
  endtask

  task automatic test_saturation();
    clear_stats(500);
    r2_read = 1'b1; r2_destination = 3'd4;
    repeat (15) cyc(CSTALL, ALL, 501);
    cyc(CQ, ALL, 502);
    repeat (4) cyc(CSTALL, ALL, 503);
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++; $display("FAIL saturate stall_cnt got=%0d want=15", stall_cnt);
    end
    cnt_clr = 1'b1;
    cyc(CSTALL, ALL, 504);
    cnt_clr = 1'b0;
    checks++;
    if (stall_cnt !== 4'd0) begin
      errors++; $display("FAIL clr_prio stall_cnt got=%0d want=0", stall_cnt);
    end
    cyc(CSTALL, ALL, 505);
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++; $display("FAIL after_clr stall_cnt got=%0d want=1", stall_cnt);
    end
    mem_rd_valid = 1'b1;
    cyc(CQ, ALL, 506);
    clear_inputs();
    cyc(CQ, ALL, 507);
  endtask

  task automatic test_back_to_back();
    clear_stats(600);
    r2_read = 1'b1; mem_rd_valid = 1'b1; r2_destination = 3'd1;
    r1_src2 = 3'd1; r1_src2_used = 1'b1;
    cyc(CBUB, ALL, 601);
    cyc(CBUB, ALL, 602);
    clear_inputs(); r2_pc_loadr = 1'b1;
    cyc(CBR, ALL, 603);
    r2_pc_loadr = 1'b0;
    cyc(CFL, ALL, 604);
    cyc(CFL, ALL, 605);
    cyc(CQ, ALL, 606);
    checks++;
    if (stall_cnt !== 4'd2 || flush_cnt !== 4'd1) begin
      errors++;
      $display("FAIL b2b counts got=%0d/%0d want=2/1", stall_cnt, flush_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_load_miss();
    test_branch();
    test_halt();
    test_priority();
    test_saturation();
    test_back_to_back();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
